id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
// - ID/EX pipeline register feeding the ALU: captures decoded operands, immediate and 4-bit Operation.
// - Selects SrcB between register and immediate, and forwards late results onto SrcA/SrcB.
// - Holds one instruction under a valid/ready handshake; supports stall and flush.
// PARAMETERS
// - DATA_WIDTH     32  operand/result width
// - OPCODE_LENGTH  4   ALU Operation width
// - REG_ADDR_W     5   register-file address width; register 0 is hard-wired zero
// PORTS
// - clk              in   1              single clock; all state on rising edge
// - reset            in   1              asynchronous, active-high
// - in_valid         in   1              decode presents an instruction
// - in_ready         out  1              stage accepts this cycle
// - in_rs1_addr      in   REG_ADDR_W     source register 1
// - in_rs2_addr      in   REG_ADDR_W     source register 2
// - in_rd_addr       in   REG_ADDR_W     destination register
// - in_rs1_data      in   DATA_WIDTH     regfile read data, rs1
// - in_rs2_data      in   DATA_WIDTH     regfile read data, rs2
// - in_imm           in   DATA_WIDTH     sign-extended immediate
// - in_alu_src       in   1              1: SrcB = imm; 0: SrcB = rs2 (rs2 unused for hazards)
// - in_operation     in   OPCODE_LENGTH  ALU opcode (bit3 = 1 for branch compares)
// - in_reg_write     in   1              instruction writes rd
// - flush            in   1              kill held and incoming instruction
// - out_valid        out  1              SrcA/SrcB/Operation valid for ALU
// - out_ready        in   1              EX consumes this cycle
// - SrcA, SrcB       out  DATA_WIDTH     ALU operands after forwarding/select
// - Operation        out  OPCODE_LENGTH  registered opcode
// - out_rd_addr      out  REG_ADDR_W     registered rd
// - out_reg_write    out  1              registered write enable
// - exmem_rd, exmem_reg_write, exmem_result  in  REG_ADDR_W/1/DATA_WIDTH  EX/MEM producer
// - memwb_rd, memwb_reg_write, memwb_result  in  REG_ADDR_W/1/DATA_WIDTH  MEM/WB producer
// BEHAVIOUR
// - Reset: out_valid=0; all stored data/addr/imm regs=0; Operation=0; out_reg_write=0.
// - in_ready = (!out_valid | out_ready) & !hazard_stall. Capture on in_valid & in_ready; latency 1 cycle.
// - Transfer out on out_valid & out_ready. Simultaneous transfer-out and capture keeps out_valid=1 (full throughput).
// - Hold: out_valid & !out_ready keeps every registered field stable, except snoop below.
// - Snoop: while holding, memwb write with memwb_rd==stored rs1/rs2 (non-zero) overwrites stored data.
//   Capture cycle applies the same snoop to in_rs*_data (write-through with regfile).
// - Forward (comb, on outputs): per operand, priority EX/MEM > MEM/WB > stored; match requires
//   reg_write=1, rd==rs, rs!=0. Register 0 never forwarded; reads 0.
// - SrcB = stored alu_src ? stored imm : forwarded rs2. Operation passes unmodified.
// - flush: next cycle out_valid=0; a same-cycle capture is discarded; flush wins over all.
// - Reset asserted mid-hold clears state immediately; no instruction survives.
// - No arithmetic here; widths pass through unchanged.
// CONFIGURATION
// - ID_EX_FORWARD_EN defined: forwarding as above; hazard_stall = 0 always.
// - Undefined: SrcA/SrcB = stored (snooped) data only; hazard_stall = 1 while incoming rs1 (or rs2 if
//   alu_src=0), non-zero, matches a writing rd in this stage (out_valid), EX/MEM, or MEM/WB.
// STRUCTURE
// - Package alu_pkg: ALU opcode localparams (AND 0000, OR 0001, ADD 0010, SUB 0011, XOR 0100, EQ 1000),
//   REG_ADDR_W, id_ex_t packed struct of registered fields.
// - Sub-module fwd_mux: one operand's 3-way priority select; instantiate twice.
// TESTING
// - Reset mid-hold: out_valid=1, out_ready=0, assert reset -> out_valid=0, SrcA=0 immediately.
// - Back-to-back: ADD x3, x1=5, x2=7, out_ready=1 every cycle -> next cycle SrcA=5, SrcB=7, Operation=0010, no bubbles.
// - Forward priority: rs1=x4, exmem(x4,1,0xAA) and memwb(x4,1,0xBB) -> SrcA=0xAA; exmem_reg_write=0 -> 0xBB.
// - x0 guard: rs1=0, exmem_rd=0, exmem_reg_write=1, result 0xFF -> SrcA=0.
// - Hold+snoop: out_ready=0 3 cycles, memwb writes x2=0x1234 in cycle 2 -> SrcB=0x1234 after release.
// - Flush: flush with in_valid=1 -> out_valid=0 next cycle; without ID_EX_FORWARD_EN, RAW on x5 in EX/MEM -> in_ready=0 until cleared.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcodes, widths and the ID/EX stage register layout.
package alu_pkg;

  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned OPCODE_LENGTH = 4;
  localparam int unsigned REG_ADDR_W    = 5;

  localparam logic [OPCODE_LENGTH-1:0] AluAnd = 4'b0000;
  localparam logic [OPCODE_LENGTH-1:0] AluOr  = 4'b0001;
  localparam logic [OPCODE_LENGTH-1:0] AluAdd = 4'b0010;
  localparam logic [OPCODE_LENGTH-1:0] AluSub = 4'b0011;
  localparam logic [OPCODE_LENGTH-1:0] AluXor = 4'b0100;
  localparam logic [OPCODE_LENGTH-1:0] AluEq  = 4'b1000;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]    rs1_addr;
    logic [REG_ADDR_W-1:0]    rs2_addr;
    logic [REG_ADDR_W-1:0]    rd_addr;
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic [DATA_WIDTH-1:0]    rs2_data;
    logic [DATA_WIDTH-1:0]    imm;
    logic                     alu_src;
    logic [OPCODE_LENGTH-1:0] operation;
    logic                     reg_write;
  } id_ex_t;

  // A producer matches a source only if it writes and the source is not x0.
  function automatic logic addr_hit(input logic [REG_ADDR_W-1:0] rs,
                                    input logic [REG_ADDR_W-1:0] rd,
                                    input logic                  we);
    return we && (rs != '0) && (rs == rd);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// One operand's forwarding select: EX/MEM over MEM/WB over stored data; x0 always reads zero.
module fwd_mux
  import alu_pkg::*;
#(
  parameter int unsigned DW = alu_pkg::DATA_WIDTH
) (
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [DW-1:0]         stored_data,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_we,
  input  logic [DW-1:0]         exmem_result,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_we,
  input  logic [DW-1:0]         memwb_result,
  output logic [DW-1:0]         fwd_data
);

  always_comb begin
    fwd_data = stored_data;
    if (rs_addr == '0) begin
      fwd_data = '0;
    end else if (addr_hit(rs_addr, exmem_rd, exmem_we)) begin
      fwd_data = exmem_result;
    end else if (addr_hit(rs_addr, memwb_rd, memwb_we)) begin
      fwd_data = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand register with valid/ready handshake, flush, MEM/WB snoop and SrcB select.
// ID_EX_FORWARD_EN enables EX/MEM and MEM/WB forwarding; otherwise RAW hazards stall decode.
module id_ex_operand_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = alu_pkg::DATA_WIDTH,
  parameter int unsigned OPCODE_LENGTH = alu_pkg::OPCODE_LENGTH,
  parameter int unsigned REG_ADDR_W    = alu_pkg::REG_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_ADDR_W-1:0]    in_rs1_addr,
  input  logic [REG_ADDR_W-1:0]    in_rs2_addr,
  input  logic [REG_ADDR_W-1:0]    in_rd_addr,
  input  logic [DATA_WIDTH-1:0]    in_rs1_data,
  input  logic [DATA_WIDTH-1:0]    in_rs2_data,
  input  logic [DATA_WIDTH-1:0]    in_imm,
  input  logic                     in_alu_src,
  input  logic [OPCODE_LENGTH-1:0] in_operation,
  input  logic                     in_reg_write,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [REG_ADDR_W-1:0]    out_rd_addr,
  output logic                     out_reg_write,
  input  logic [REG_ADDR_W-1:0]    exmem_rd,
  input  logic                     exmem_reg_write,
  input  logic [DATA_WIDTH-1:0]    exmem_result,
  input  logic [REG_ADDR_W-1:0]    memwb_rd,
  input  logic                     memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]    memwb_result
);

  id_ex_t stage_q, stage_d, src_sel;
  logic   valid_q, valid_d;
  logic   hazard_stall, accept;
  logic   exmem_fwd_we, memwb_fwd_we;
  logic [DATA_WIDTH-1:0] rs2_fwd;

`ifdef ID_EX_FORWARD_EN
  assign exmem_fwd_we = exmem_reg_write;
  assign memwb_fwd_we = memwb_reg_write;
  assign hazard_stall = 1'b0;
`else
  logic rs1_raw, rs2_raw;
  assign exmem_fwd_we = 1'b0;
  assign memwb_fwd_we = 1'b0;
  assign rs1_raw = addr_hit(in_rs1_addr, stage_q.rd_addr, valid_q && stage_q.reg_write) ||
                   addr_hit(in_rs1_addr, exmem_rd, exmem_reg_write) ||
                   addr_hit(in_rs1_addr, memwb_rd, memwb_reg_write);
  assign rs2_raw = addr_hit(in_rs2_addr, stage_q.rd_addr, valid_q && stage_q.reg_write) ||
                   addr_hit(in_rs2_addr, exmem_rd, exmem_reg_write) ||
                   addr_hit(in_rs2_addr, memwb_rd, memwb_reg_write);
  assign hazard_stall = rs1_raw || (!in_alu_src && rs2_raw);
`endif

  assign in_ready = (!valid_q || out_ready) && !hazard_stall;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    src_sel = stage_q;
    if (accept) begin
      src_sel = '{rs1_addr: in_rs1_addr, rs2_addr: in_rs2_addr, rd_addr: in_rd_addr,
                  rs1_data: in_rs1_data, rs2_data: in_rs2_data, imm: in_imm,
                  alu_src: in_alu_src, operation: in_operation, reg_write: in_reg_write};
    end
    // Write-through of the MEM/WB result, both into a held entry and into one being captured.
    stage_d = src_sel;
    if (addr_hit(src_sel.rs1_addr, memwb_rd, memwb_reg_write)) stage_d.rs1_data = memwb_result;
    if (addr_hit(src_sel.rs2_addr, memwb_rd, memwb_reg_write)) stage_d.rs2_data = memwb_result;
  end

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      stage_q <= '0;
    end else begin
      valid_q <= valid_d;
      stage_q <= stage_d;
    end
  end

  fwd_mux #(.DW(DATA_WIDTH)) u_fwd_rs1 (
    .rs_addr     (stage_q.rs1_addr),
    .stored_data (stage_q.rs1_data),
    .exmem_rd    (exmem_rd),
    .exmem_we    (exmem_fwd_we),
    .exmem_result(exmem_result),
    .memwb_rd    (memwb_rd),
    .memwb_we    (memwb_fwd_we),
    .memwb_result(memwb_result),
    .fwd_data    (SrcA)
  );

  fwd_mux #(.DW(DATA_WIDTH)) u_fwd_rs2 (
    .rs_addr     (stage_q.rs2_addr),
    .stored_data (stage_q.rs2_data),
    .exmem_rd    (exmem_rd),
    .exmem_we    (exmem_fwd_we),
    .exmem_result(exmem_result),
    .memwb_rd    (memwb_rd),
    .memwb_we    (memwb_fwd_we),
    .memwb_result(memwb_result),
    .fwd_data    (rs2_fwd)
  );

  assign SrcB          = stage_q.alu_src ? stage_q.imm : rs2_fwd;
  assign out_valid     = valid_q;
  assign Operation     = stage_q.operation;
  assign out_rd_addr   = stage_q.rd_addr;
  assign out_reg_write = stage_q.reg_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage; expectations follow ID_EX_FORWARD_EN if defined.
module tb_id_ex_operand_stage;

`ifdef ID_EX_FORWARD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_alu_src;
  logic [3:0]  in_operation;
  logic        in_reg_write;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] SrcA, SrcB;
  logic [3:0]  Operation;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  id_ex_operand_stage dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rs1_addr    (in_rs1_addr),
    .in_rs2_addr    (in_rs2_addr),
    .in_rd_addr     (in_rd_addr),
    .in_rs1_data    (in_rs1_data),
    .in_rs2_data    (in_rs2_data),
    .in_imm         (in_imm),
    .in_alu_src     (in_alu_src),
    .in_operation   (in_operation),
    .in_reg_write   (in_reg_write),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .SrcA           (SrcA),
    .SrcB           (SrcB),
    .Operation      (Operation),
    .out_rd_addr    (out_rd_addr),
    .out_reg_write  (out_reg_write),
    .exmem_rd       (exmem_rd),
    .exmem_reg_write(exmem_reg_write),
    .exmem_result   (exmem_result),
    .memwb_rd       (memwb_rd),
    .memwb_reg_write(memwb_reg_write),
    .memwb_result   (memwb_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic src, input logic [3:0] op, input logic we);
    in_rs1_addr  = rs1;
    in_rs2_addr  = rs2;
    in_rd_addr   = rd;
    in_rs1_data  = d1;
    in_rs2_data  = d2;
    in_imm       = imm;
    in_alu_src   = src;
    in_operation = op;
    in_reg_write = we;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
    exmem_rd = 5'd0; exmem_reg_write = 1'b0; exmem_result = 32'h0;
    memwb_rd = 5'd0; memwb_reg_write = 1'b0; memwb_result = 32'h0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_srca", SrcA, 0);
    check("rst_srcb", SrcB, 0);
    check("rst_operation", Operation, 0);
    check("rst_reg_write", out_reg_write, 0);
    check("rst_in_ready", in_ready, 1);
    cyc();
    reset = 1'b0;

    // Back-to-back: ADD x3 <- x1(5), x2(7), then SUB x6 <- x1(9), imm 0x10
    out_ready = 1'b1; in_valid = 1'b1;
    drive(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 1'b0, 4'b0010, 1'b1);
    #1 check("b2b_in_ready0", in_ready, 1);
    cyc();
    check("b2b_valid0", out_valid, 1);
    check("b2b_srca0", SrcA, 32'd5);
    check("b2b_srcb0", SrcB, 32'd7);
    check("b2b_op0", Operation, 4'b0010);
    check("b2b_rd0", out_rd_addr, 5'd3);
    check("b2b_we0", out_reg_write, 1);
    drive(5'd1, 5'd3, 5'd6, 32'd9, 32'hdead, 32'h10, 1'b1, 4'b0011, 1'b1);
    #1 check("b2b_in_ready1", in_ready, 1);
    cyc();
    check("b2b_valid1", out_valid, 1);
    check("b2b_srca1", SrcA, 32'd9);
    check("b2b_srcb1", SrcB, 32'h10);
    check("b2b_op1", Operation, 4'b0011);

    // RAW against this stage's own rd (x6)
    drive(5'd6, 5'd0, 5'd8, 32'd1, 32'd0, 32'h4, 1'b1, 4'b0000, 1'b1);
    #1 check("raw_stage_ready", in_ready, Fwd ? 1 : 0);
    cyc();
    check("raw_stage_valid", out_valid, Fwd ? 1 : 0);
    check("raw_stage_ready_after", in_ready, 1);
    in_valid = 1'b0;
    cyc();
    check("drain_valid", out_valid, 0);

    // RAW on x5 in EX/MEM (rs1), then MEM/WB (rs2, register operand)
    exmem_rd = 5'd5; exmem_reg_write = 1'b1; exmem_result = 32'h55;
    in_valid = 1'b1;
    drive(5'd5, 5'd0, 5'd9, 32'd0, 32'd0, 32'h0, 1'b1, 4'b0010, 1'b1);
    #1 check("raw_exmem_ready", in_ready, Fwd ? 1 : 0);
    exmem_reg_write = 1'b0;
    #1 check("raw_exmem_cleared", in_ready, 1);
    memwb_rd = 5'd5; memwb_reg_write = 1'b1;
    drive(5'd1, 5'd5, 5'd9, 32'd0, 32'd0, 32'h0, 1'b0, 4'b0010, 1'b1);
    #1 check("raw_memwb_rs2_ready", in_ready, Fwd ? 1 : 0);
    memwb_reg_write = 1'b0; in_valid = 1'b0;
    #1;

    // Hold + snoop: XOR x7 <- x1(0x11), x2(0x22); MEM/WB writes x2 = 0x1234 mid-hold
    in_valid = 1'b1; out_ready = 1'b0;
    drive(5'd1, 5'd2, 5'd7, 32'h11, 32'h22, 32'h0, 1'b0, 4'b0100, 1'b1);
    cyc();
    in_valid = 1'b0;
    check("hold_valid", out_valid, 1);
    check("hold_srcb_before", SrcB, 32'h22);
    cyc();
    memwb_rd = 5'd2; memwb_reg_write = 1'b1; memwb_result = 32'h1234;
    #1 check("hold_srcb_memwb_live", SrcB, Fwd ? 32'h1234 : 32'h22);
    cyc();
    memwb_reg_write = 1'b0;
    #1 check("hold_srcb_snooped", SrcB, 32'h1234);
    cyc();
    check("hold_valid_end", out_valid, 1);
    check("hold_srca_end", SrcA, 32'h11);
    check("hold_op_end", Operation, 4'b0100);
    out_ready = 1'b1;
    cyc();
    check("hold_release_valid", out_valid, 0);

    // Forward priority on held rs1 = x4
    in_valid = 1'b1; out_ready = 1'b0;
    drive(5'd4, 5'd0, 5'd12, 32'h44, 32'h0, 32'h0, 1'b0, 4'b0001, 1'b1);
    cyc();
    in_valid = 1'b0;
    exmem_rd = 5'd4; exmem_reg_write = 1'b1; exmem_result = 32'hAA;
    memwb_rd = 5'd4; memwb_reg_write = 1'b1; memwb_result = 32'hBB;
    #1 check("fwd_prio_exmem", SrcA, Fwd ? 32'hAA : 32'h44);
    check("fwd_srcb_x0", SrcB, 32'h0);
    exmem_reg_write = 1'b0;
    #1 check("fwd_prio_memwb", SrcA, Fwd ? 32'hBB : 32'h44);
    memwb_reg_write = 1'b0;

    // x0 guard: rs1 = x0 with EX/MEM claiming to write x0
    out_ready = 1'b1; in_valid = 1'b1;
    drive(5'd0, 5'd0, 5'd13, 32'h0, 32'h0, 32'h0, 1'b0, 4'b0010, 1'b1);
    cyc();
    out_ready = 1'b0; in_valid = 1'b0;
    exmem_rd = 5'd0; exmem_reg_write = 1'b1; exmem_result = 32'hFF;
    #1 check("x0_srca", SrcA, 32'h0);
    check("x0_valid", out_valid, 1);
    exmem_reg_write = 1'b0;

    // Capture-cycle snoop: x1 written by MEM/WB while being read
    out_ready = 1'b1; in_valid = 1'b1;
    memwb_rd = 5'd1; memwb_reg_write = 1'b1; memwb_result = 32'h99;
    drive(5'd1, 5'd0, 5'd14, 32'h11, 32'h0, 32'h0, 1'b0, 4'b0010, 1'b1);
    cyc();
    memwb_reg_write = 1'b0; in_valid = 1'b0;
    #1 check("cap_snoop_valid", out_valid, Fwd ? 1 : 0);
`ifdef ID_EX_FORWARD_EN
    check("cap_snoop_srca", SrcA, 32'h99);
`endif

    // Flush of a held entry with a same-cycle incoming instruction, then of a capture
    out_ready = 1'b1; in_valid = 1'b1;
    drive(5'd1, 5'd0, 5'd10, 32'h1, 32'h0, 32'h0, 1'b0, 4'b1000, 1'b0);
    cyc();
    check("flush_pre_valid", out_valid, 1);
    out_ready = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("flush_held_valid", out_valid, 0);
    out_ready = 1'b1; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_capture_valid", out_valid, 0);

    // Asynchronous reset mid-hold
    in_valid = 1'b1; out_ready = 1'b1;
    drive(5'd1, 5'd0, 5'd11, 32'h77, 32'h0, 32'h0, 1'b0, 4'b0010, 1'b1);
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    check("mid_hold_valid", out_valid, 1);
    check("mid_hold_srca", SrcA, 32'h77);
    #2 reset = 1'b1;
    #1 check("async_rst_valid", out_valid, 0);
    check("async_rst_srca", SrcA, 32'h0);
    check("async_rst_rd", out_rd_addr, 5'd0);
    cyc();
    reset = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
